// File: rtl/xsleena_loader_pkg.sv
// xsleena_loader_pkg: loader FSM states and the fixed ROM region map
package xsleena_loader_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, DONE} loader_state_t;
  localparam int NREG_MAP = 4;
  localparam int REG_MAP = 0;
  localparam int REG_BG = 1;
  localparam int REG_OBJ = 2;
  localparam int REG_PROM = 3;
  localparam logic [24:0] REG_BASE [NREG_MAP] = '{
    REG_MAP: 25'h00000, REG_BG: 25'h08000, REG_OBJ: 25'h48000, REG_PROM: 25'hC8000
  };
  localparam logic [24:0] REG_SIZE [NREG_MAP] = '{
    REG_MAP: 25'h08000, REG_BG: 25'h40000, REG_OBJ: 25'h80000, REG_PROM: 25'h00800
  };
endpackage

// File: rtl/xsleena_rom_loader_if.sv
// xsleena_rom_loader_if: HPS ioctl download stream with its wait back-pressure
interface xsleena_rom_loader_if;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  modport master (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    input  ioctl_wait
  );
  modport slave (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    output ioctl_wait
  );
endinterface

// File: rtl/xsleena_loader_region_dec.sv
// xsleena_loader_region_dec: linear address to one-hot region select and rebased offset
module xsleena_loader_region_dec
  import xsleena_loader_pkg::*;
#(
  parameter int NREG = 4
) (
  input  logic [24:0]     addr,
  output logic            hit,
  output logic [NREG-1:0] sel,
  output logic [19:0]     offset
);
  logic [24:0] diff;
  // Descending scan so the lowest matching region wins
  always_comb begin
    hit = 1'b0;
    sel = '0;
    diff = '0;
    for (int r = NREG - 1; r >= 0; r--) begin
      if ({1'b0, addr} >= {1'b0, REG_BASE[r]} &&
          {1'b0, addr} < {1'b0, REG_BASE[r]} + {1'b0, REG_SIZE[r]}) begin
        hit = 1'b1;
        sel = '0;
        sel[r] = 1'b1;
        diff = addr - REG_BASE[r];
      end
    end
  end
  assign offset = diff[19:0];
endmodule

// File: rtl/xsleena_rom_loader.sv
// xsleena_rom_loader: HPS ioctl ROM stream to per-region BRAM writes with stretched strobe.
// Define XSLEENA_LOADER_CHECKSUM_EN to add ld_sum/ld_count load statistics.
module xsleena_rom_loader
  import xsleena_loader_pkg::*;
#(
  parameter int          NREG      = 4,
  parameter logic [7:0]  ROM_INDEX = 8'd0,
  parameter int          WR_CYCLES = 2
) (
  input  logic              clk,
  input  logic              RESETn,
  xsleena_rom_loader_if.slave io,
  output logic              bram_wr,
  output logic [7:0]        bram_data,
  output logic [19:0]       bram_addr,
  output logic [NREG-1:0]   bram_cs,
  output logic              load_busy,
  output logic              load_done,
  output logic              err_overrun
`ifdef XSLEENA_LOADER_CHECKSUM_EN
  ,
  output logic [15:0]       ld_sum,
  output logic [24:0]       ld_count
`endif
);
  loader_state_t   state, nxt;
  logic            act_r;
  logic [2:0]      cnt;
  logic            hit;
  logic [NREG-1:0] sel;
  logic [19:0]     offset;
  logic            busy_wr, accept_wr, take, enter_load;
  xsleena_loader_region_dec #(.NREG(NREG)) u_dec (
    .addr   (io.ioctl_addr),
    .hit    (hit),
    .sel    (sel),
    .offset (offset)
  );
  assign busy_wr    = cnt != 3'd0;
  assign accept_wr  = state == LOAD && io.ioctl_wr;
  assign take       = accept_wr && !busy_wr && hit;
  assign enter_load = state != LOAD && nxt == LOAD;
  assign bram_wr    = busy_wr;
  assign io.ioctl_wait = busy_wr;
  assign load_busy  = state == LOAD;
  assign load_done  = state == DONE;
  always_ff @(posedge clk or negedge RESETn) begin
    if (!RESETn) state <= IDLE;
    else state <= nxt;
  end
  // A pending write holds off DONE until its strobe completes
  always_comb begin
    nxt = state;
    nxt = state == LOAD ? ((!act_r && !busy_wr) ? DONE : LOAD) : (act_r ? LOAD : state);
  end
  always_ff @(posedge clk or negedge RESETn) begin
    if (!RESETn) begin
      act_r <= 1'b0;
      cnt <= 3'd0;
      bram_cs <= '0;
      bram_addr <= '0;
      bram_data <= '0;
      err_overrun <= 1'b0;
    end else begin
      act_r <= io.ioctl_download && io.ioctl_index == ROM_INDEX;
      if (enter_load) err_overrun <= 1'b0;
      else if (accept_wr && busy_wr) err_overrun <= 1'b1;
      if (take) begin
        cnt <= 3'(WR_CYCLES);
        bram_cs <= sel;
        bram_addr <= offset;
        bram_data <= io.ioctl_dout;
      end else if (busy_wr) begin
        cnt <= cnt - 3'd1;
        if (cnt == 3'd1) bram_cs <= '0;
      end
    end
  end
`ifdef XSLEENA_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge RESETn) begin
    if (!RESETn) begin
      ld_sum <= '0;
      ld_count <= '0;
    end else if (enter_load) begin
      ld_sum <= '0;
      ld_count <= '0;
    end else if (take) begin
      ld_sum <= ld_sum + {8'd0, io.ioctl_dout};
      ld_count <= ld_count + 25'd1;
    end
  end
`endif
endmodule

// File: tb/tb_xsleena_rom_loader.sv
// tb_xsleena_rom_loader: randomized ROM stream against a region-table reference model
module tb_xsleena_rom_loader;
  localparam int W = 2;
  logic        clk;
  logic        RESETn;
  logic        bram_wr;
  logic [7:0]  bram_data;
  logic [19:0] bram_addr;
  logic [3:0]  bram_cs;
  logic        load_busy, load_done, err_overrun;
`ifdef XSLEENA_LOADER_CHECKSUM_EN
  logic [15:0] ld_sum;
  logic [24:0] ld_count;
`endif
  int total = 0;
  int bad = 0;
  int bases [4] = '{'h00000, 'h08000, 'h48000, 'hC8000};
  int sizes [4] = '{'h08000, 'h40000, 'h80000, 'h00800};
  logic [15:0] exp_sum;
  int exp_cnt;
  xsleena_rom_loader_if io ();
  xsleena_rom_loader #(.NREG(4), .ROM_INDEX(8'd0), .WR_CYCLES(W)) dut (
    .clk         (clk),
    .RESETn      (RESETn),
    .io          (io),
    .bram_wr     (bram_wr),
    .bram_data   (bram_data),
    .bram_addr   (bram_addr),
    .bram_cs     (bram_cs),
    .load_busy   (load_busy),
    .load_done   (load_done),
    .err_overrun (err_overrun)
`ifdef XSLEENA_LOADER_CHECKSUM_EN
    ,
    .ld_sum      (ld_sum),
    .ld_count    (ld_count)
`endif
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic int ref_region(input logic [24:0] a);
    for (int r = 0; r < 4; r++)
      if (int'(a) >= bases[r] && int'(a) < bases[r] + sizes[r]) return r;
    return -1;
  endfunction
  task automatic send(input logic [24:0] a, input logic [7:0] d, input bit en);
    int r;
    logic [19:0] off;
    bit wr;
    r = en ? ref_region(a) : -1;
    off = 20'(int'(a) - (r >= 0 ? bases[r] : 0));
    io.ioctl_wr = 1'b1;
    io.ioctl_addr = a;
    io.ioctl_dout = d;
    tick();
    io.ioctl_wr = 1'b0;
    for (int k = 0; k <= W; k++) begin
      wr = r >= 0 && k < W;
      chk("bram_wr", bram_wr, wr);
      chk("ioctl_wait", io.ioctl_wait, wr);
      chk("bram_cs", bram_cs, wr ? (32'd1 << r) : 32'd0);
      if (wr) begin
        chk("bram_addr", bram_addr, off);
        chk("bram_data", bram_data, d);
      end
      tick();
    end
    if (r >= 0) begin
      exp_sum += 16'(d);
      exp_cnt++;
    end
  endtask
  task automatic start_dl(input logic [7:0] idx);
    io.ioctl_download = 1'b1;
    io.ioctl_index = idx;
    tick();
    tick();
    exp_sum = '0;
    exp_cnt = 0;
  endtask
  task automatic stop_dl();
    int n;
    n = 0;
    io.ioctl_download = 1'b0;
    while (!load_done && n < 20) begin
      tick();
      n++;
    end
    chk("stop_done", load_done, 1);
    chk("stop_busy", load_busy, 0);
  endtask
  initial begin
    int n, wrs, r;
    logic [24:0] a;
    RESETn = 1'b0;
    io.ioctl_download = 1'b0;
    io.ioctl_index = 8'd0;
    io.ioctl_wr = 1'b0;
    io.ioctl_addr = '0;
    io.ioctl_dout = '0;
    exp_sum = '0;
    exp_cnt = 0;
    #1;
    chk("rst_wr", bram_wr, 0);
    chk("rst_wait", io.ioctl_wait, 0);
    chk("rst_cs", bram_cs, 0);
    chk("rst_addr", bram_addr, 0);
    chk("rst_data", bram_data, 0);
    chk("rst_busy", load_busy, 0);
    chk("rst_done", load_done, 0);
    chk("rst_err", err_overrun, 0);
    tick();
    tick();
    RESETn = 1'b1;
    tick();
    start_dl(8'd0);
    chk("start_busy", load_busy, 1);
    chk("start_done", load_done, 0);
    send(25'h00005, 8'hA5, 1'b1);
    send(25'h08010, 8'h3C, 1'b1);
    send(25'hC8800, 8'h77, 1'b1);
    send(25'h07FFF, 8'h12, 1'b1);
    send(25'h08000, 8'h34, 1'b1);
    send(25'hC87FF, 8'h56, 1'b1);
    send(25'h1C8005, 8'h9A, 1'b1);
    // back-to-back strobe: second byte lands in the first byte's write window
    io.ioctl_wr = 1'b1;
    io.ioctl_addr = 25'h00100;
    io.ioctl_dout = 8'h11;
    tick();
    io.ioctl_addr = 25'h00200;
    io.ioctl_dout = 8'h22;
    tick();
    io.ioctl_wr = 1'b0;
    chk("ovr_wr", bram_wr, 1);
    chk("ovr_addr", bram_addr, 20'h00100);
    chk("ovr_data", bram_data, 8'h11);
    chk("ovr_err", err_overrun, 1);
    tick();
    chk("ovr_wr_end", bram_wr, 0);
    tick();
    chk("ovr_no_burst", bram_wr, 0);
    chk("ovr_err_hold", err_overrun, 1);
    stop_dl();
    chk("done_err_hold", err_overrun, 1);
    start_dl(8'd0);
    chk("restart_err", err_overrun, 0);
    chk("restart_busy", load_busy, 1);
    send(25'h00040, 8'h01, 1'b1);
    send(25'h00041, 8'hFF, 1'b1);
    send(25'h00042, 8'h10, 1'b1);
`ifdef XSLEENA_LOADER_CHECKSUM_EN
    chk("ld_sum3", ld_sum, 16'h0110);
    chk("ld_count3", ld_count, 3);
`endif
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 4);
      a = r < 4 ? 25'(bases[r] + $urandom_range(0, sizes[r] - 1)) : 25'($urandom);
      send(a, 8'($urandom), 1'b1);
      n = $urandom_range(0, 2);
      for (int j = 0; j < n; j++) tick();
    end
    chk("rand_err", err_overrun, 0);
`ifdef XSLEENA_LOADER_CHECKSUM_EN
    chk("ld_sum", ld_sum, exp_sum);
    chk("ld_count", ld_count, exp_cnt);
`endif
    io.ioctl_wr = 1'b1;
    io.ioctl_addr = 25'h00030;
    io.ioctl_dout = 8'h5A;
    tick();
    io.ioctl_wr = 1'b0;
    io.ioctl_download = 1'b0;
    n = 0;
    wrs = 0;
    while (!load_done && n < 20) begin
      if (bram_wr) wrs++;
      tick();
      n++;
    end
    chk("fall_wrs", wrs, W);
    chk("fall_done", load_done, 1);
    chk("fall_busy", load_busy, 0);
    chk("fall_wr", bram_wr, 0);
    io.ioctl_download = 1'b1;
    io.ioctl_index = 8'd1;
    tick();
    tick();
    tick();
    chk("idx_busy", load_busy, 0);
    send(25'h00010, 8'hEE, 1'b0);
    chk("idx_busy2", load_busy, 0);
    io.ioctl_download = 1'b0;
    tick();
    start_dl(8'd0);
    io.ioctl_wr = 1'b1;
    io.ioctl_addr = 25'h48004;
    io.ioctl_dout = 8'hC3;
    tick();
    io.ioctl_wr = 1'b0;
    chk("pre_rst_wr", bram_wr, 1);
    #2;
    RESETn = 1'b0;
    #1;
    chk("arst_wr", bram_wr, 0);
    chk("arst_wait", io.ioctl_wait, 0);
    chk("arst_cs", bram_cs, 0);
    chk("arst_addr", bram_addr, 0);
    chk("arst_data", bram_data, 0);
    chk("arst_busy", load_busy, 0);
    chk("arst_done", load_done, 0);
    chk("arst_err", err_overrun, 0);
    tick();
    RESETn = 1'b1;
    tick();
    chk("post_rst_wr", bram_wr, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
